// File: rtl/pc_unit.sv
// Fetch program counter with trap/redirect/stall priority and a circular return-address stack.
// Optional feature: define PC_MISALIGN_CHECK_EN to divert misaligned redirect/call targets to TRAP_VECTOR.
module pc_unit #(
    parameter int unsigned                ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0]      TRAP_VECTOR  = ADDR_WIDTH'('h100),
    parameter int unsigned                PC_INC       = 4,
    parameter int unsigned                RAS_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          trap,
    input  logic                          redirect,
    input  logic [ADDR_WIDTH-1:0]         redirectAddr,
    input  logic                          call,
    input  logic [ADDR_WIDTH-1:0]         callTarget,
    input  logic                          ret,
    output logic [ADDR_WIDTH-1:0]         addrOut,
    output logic [$clog2(RAS_DEPTH):0]    rasCount,
    output logic                          rasUnderflow,
    output logic                          misaligned
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(PC_INC - 1);
    localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(PC_INC);
    localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  unf_q, unf_d;
    logic                  mis_q, mis_d;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

    logic                  ras_we;
    logic [PTR_W-1:0]      ras_widx;
    logic [ADDR_WIDTH-1:0] ras_wdata;

    logic [ADDR_WIDTH-1:0] pc_plus;
    logic [PTR_W-1:0]      top_idx;
    logic [PTR_W-1:0]      ptr_inc;
    logic [CNT_W-1:0]      cnt_sat_inc;
    logic                  redir_bad;
    logic                  call_bad;

    assign pc_plus     = pc_q + INC;
    // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
    assign top_idx     = ptr_q - PTR_W'(1);
    assign ptr_inc     = ptr_q + PTR_W'(1);
    assign cnt_sat_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef PC_MISALIGN_CHECK_EN
    assign redir_bad = |(redirectAddr & ALIGN_MASK);
    assign call_bad  = |(callTarget & ALIGN_MASK);
`else
    assign redir_bad = 1'b0;
    assign call_bad  = 1'b0;
`endif

    always_comb begin
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        unf_d     = 1'b0;
        mis_d     = 1'b0;
        ras_we    = 1'b0;
        ras_widx  = ptr_q;
        ras_wdata = pc_plus;

        if (trap) begin
            pc_d  = TRAP_VECTOR;
            ptr_d = '0;
            cnt_d = '0;
        end else if (redirect) begin
            if (redir_bad) begin
                pc_d  = TRAP_VECTOR;
                ptr_d = '0;
                cnt_d = '0;
                mis_d = 1'b1;
            end else begin
                pc_d = redirectAddr;
            end
        end else if (stall) begin
            pc_d = pc_q;
        end else if (call && ret) begin
            if (call_bad) begin
                pc_d  = TRAP_VECTOR;
                ptr_d = '0;
                cnt_d = '0;
                mis_d = 1'b1;
            end else if (cnt_q == '0) begin
                // Empty stack: nothing to replace, so behave as a plain push.
                pc_d   = callTarget;
                ras_we = 1'b1;
                ptr_d  = ptr_inc;
                cnt_d  = cnt_sat_inc;
            end else begin
                pc_d     = callTarget;
                ras_we   = 1'b1;
                ras_widx = top_idx;
            end
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[top_idx];
                ptr_d = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = pc_plus;
                unf_d = 1'b1;
            end
        end else if (call) begin
            if (call_bad) begin
                pc_d  = TRAP_VECTOR;
                ptr_d = '0;
                cnt_d = '0;
                mis_d = 1'b1;
            end else begin
                // On overflow the pointer laps and the oldest entry is overwritten.
                pc_d   = callTarget;
                ras_we = 1'b1;
                ptr_d  = ptr_inc;
                cnt_d  = cnt_sat_inc;
            end
        end else begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            unf_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            unf_q <= unf_d;
            mis_q <= mis_d;
        end
    end

    // Stack contents are don't-care after reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_widx] <= ras_wdata;
        end
    end

    assign addrOut      = pc_q;
    assign rasCount     = cnt_q;
    assign rasUnderflow = unf_q;
    assign misaligned   = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, priority, call/return, overflow, call+ret, misalign, wrap.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        trap;
    logic        redirect;
    logic [31:0] redirectAddr;
    logic        call;
    logic [31:0] callTarget;
    logic        ret;
    logic [31:0] addrOut;
    logic [2:0]  rasCount;
    logic        rasUnderflow;
    logic        misaligned;

    int n_vec = 0;
    int n_err = 0;

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .trap         (trap),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .call         (call),
        .callTarget   (callTarget),
        .ret          (ret),
        .addrOut      (addrOut),
        .rasCount     (rasCount),
        .rasUnderflow (rasUnderflow),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trap = 0; redirect = 0; redirectAddr = '0; stall = 0;
        call = 0; callTarget = '0; ret = 0;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        idle(); redirect = 1; redirectAddr = a; tick(); idle();
    endtask

    task automatic do_call(input logic [31:0] t);
        idle(); call = 1; callTarget = t; tick(); idle();
    endtask

    task automatic do_ret();
        idle(); ret = 1; tick(); idle();
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
        check({tag, ".pc"}, addrOut, pc);
        check({tag, ".cnt"}, 32'(rasCount), 32'(cnt));
    endtask

    initial begin
        idle();
        rst = 0;
        #3;
        check("rst.pc", addrOut, 32'h0);
        check("rst.cnt", 32'(rasCount), 32'd0);
        check("rst.unf", 32'(rasUnderflow), 32'd0);
        check("rst.mis", 32'(misaligned), 32'd0);
        tick(); tick();
        rst = 1;
        check("rel.pc", addrOut, 32'h0);
        repeat (15) tick();
        check("run.pc", addrOut, 32'h3c);
        do_call(32'h40);
        expect_state("pre_rst", 32'h40, 3'd1);

        // Asynchronous reset mid-cycle.
        #2 rst = 0;
        #1;
        expect_state("async_rst", 32'h0, 3'd0);
        tick();
        rst = 1;
        check("rel2.pc0", addrOut, 32'h0);
        tick(); check("rel2.pc4", addrOut, 32'h4);
        tick(); check("rel2.pc8", addrOut, 32'h8);
        tick(); check("rel2.pc12", addrOut, 32'hc);

        // Priority: trap beats redirect and stall, and flushes the RAS.
        do_call(32'h30);
        expect_state("prio.call", 32'h30, 3'd1);
        trap = 1; redirect = 1; redirectAddr = 32'h200; stall = 1;
        tick(); idle();
        expect_state("prio.trap", 32'h100, 3'd0);
        redirect = 1; redirectAddr = 32'h200; stall = 1;
        tick(); idle();
        check("prio.redir", addrOut, 32'h200);
        stall = 1; call = 1; callTarget = 32'h400;
        tick(); idle();
        expect_state("stall.hold", 32'h200, 3'd0);

        // Call / return / underflow.
        do_redirect(32'h10);
        do_call(32'h80);
        expect_state("cr.call", 32'h80, 3'd1);
        do_ret();
        expect_state("cr.ret", 32'h14, 3'd0);
        check("cr.unf0", 32'(rasUnderflow), 32'd0);
        do_ret();
        check("cr.ret_empty", addrOut, 32'h18);
        check("cr.unf1", 32'(rasUnderflow), 32'd1);
        tick();
        check("cr.unf_pulse", 32'(rasUnderflow), 32'd0);
        check("cr.seq", addrOut, 32'h1c);

        // Overflow: five nested calls into a depth-4 stack.
        do_redirect(32'h0);
        do_call(32'h100);
        do_call(32'h200);
        do_call(32'h300);
        do_call(32'h400);
        do_call(32'h500);
        expect_state("ovf.calls", 32'h500, 3'd4);
        do_ret(); expect_state("ovf.r1", 32'h404, 3'd3);
        do_ret(); expect_state("ovf.r2", 32'h304, 3'd2);
        do_ret(); expect_state("ovf.r3", 32'h204, 3'd1);
        do_ret(); expect_state("ovf.r4", 32'h104, 3'd0);
        do_ret();
        check("ovf.r5.pc", addrOut, 32'h108);
        check("ovf.r5.unf", 32'(rasUnderflow), 32'd1);

        // Simultaneous call+ret replaces the top entry.
        do_redirect(32'h20);
        do_call(32'h50);
        expect_state("cr2.setup", 32'h50, 3'd1);
        call = 1; ret = 1; callTarget = 32'h90;
        tick(); idle();
        expect_state("cr2.both", 32'h90, 3'd1);
        do_ret();
        expect_state("cr2.top", 32'h54, 3'd0);
        call = 1; ret = 1; callTarget = 32'ha0;
        tick(); idle();
        expect_state("cr2.empty_push", 32'ha0, 3'd1);
        do_ret();
        expect_state("cr2.pop", 32'h58, 3'd0);

        // Misaligned redirect target.
        do_call(32'h300);
        expect_state("mis.setup", 32'h300, 3'd1);
        do_redirect(32'h202);
`ifdef PC_MISALIGN_CHECK_EN
        expect_state("mis.redir", 32'h100, 3'd0);
        check("mis.flag", 32'(misaligned), 32'd1);
`else
        expect_state("mis.redir", 32'h202, 3'd1);
        check("mis.flag", 32'(misaligned), 32'd0);
`endif
        tick();
        check("mis.pulse", 32'(misaligned), 32'd0);

        // Wrap at the top of the address space.
        do_redirect(32'hffff_fffc);
        check("wrap.max", addrOut, 32'hffff_fffc);
        tick();
        check("wrap.zero", addrOut, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch program counter; next generation of the single-cycle PC block.
- Adds configurable width, reset and trap vectors, and increment step.
- Adds a stall hold, prioritised trap and redirect inputs, and a circular return-address stack (RAS) driven by call/return hints.
- Sits at the head of fetch; addrOut drives the instruction memory address.

Parameters:
- ADDR_WIDTH, 32, width of every address port and of the internal PC.
- RESET_VECTOR, 0, PC value loaded while reset is asserted.
- TRAP_VECTOR, 'h100, PC value loaded on trap.
- PC_INC, 4, sequential increment; must be a power of two.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset; asserted at 0.
- stall  in  1  hold the PC this cycle.
- trap  in  1  load TRAP_VECTOR and flush the RAS.
- redirect  in  1  load redirectAddr (branch/jump resolution).
- redirectAddr  in  ADDR_WIDTH  redirect target.
- call  in  1  current instruction is a call: push addrOut+PC_INC, load callTarget.
- callTarget  in  ADDR_WIDTH  call target.
- ret  in  1  current instruction is a return: pop the RAS, load the popped address.
- addrOut  out  ADDR_WIDTH  current PC.
- rasCount  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- rasUnderflow  out  1  one-cycle pulse: ret seen with an empty RAS.
- misaligned  out  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - addrOut=RESET_VECTOR.
  - rasCount=0, RAS pointer=0.
  - rasUnderflow=0, misaligned=0.
  - RAS contents are don't-care.
- Release is synchronous to the next clk edge; the first fetch address is RESET_VECTOR.
- Each rising edge, exactly one action, highest priority first:
  1. trap: pc<=TRAP_VECTOR; rasCount<=0; pointer<=0.
  2. redirect: pc<=redirectAddr; RAS unchanged.
  3. stall: pc held; call/ret ignored; RAS unchanged.
  4. call and ret together: pc<=callTarget; top entry overwritten with pc+PC_INC; rasCount unchanged. If the RAS is empty, this acts as a push.
  5. ret:
     - rasCount>0: pc<=top entry; pointer decrements (mod RAS_DEPTH); rasCount decrements.
     - rasCount==0: pc<=pc+PC_INC and rasUnderflow pulses.
  6. call: entry[pointer]<=pc+PC_INC; pointer increments (mod RAS_DEPTH); pc<=callTarget; rasCount increments, saturating at RAS_DEPTH. On overflow the oldest entry is silently overwritten.
  7. otherwise: pc<=pc+PC_INC.
- Arithmetic is modulo 2^ADDR_WIDTH; the PC wraps from max to 0 with no flag.
- Latency: every action takes one cycle; addrOut is registered, with no combinational path from inputs.
- rasUnderflow and misaligned are registered and high for exactly the one cycle after the causing edge.
- "Top" means entry[(pointer-1) mod RAS_DEPTH].
- RAS storage is a register array; no read-during-write hazard, because call+ret uses the pre-edge top.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - A redirect or call whose target has nonzero bits [log2(PC_INC)-1:0] is not taken.
  - Instead pc<=TRAP_VECTOR, the RAS is flushed as for trap, and misaligned pulses for one cycle.
  - The check applies only when that action wins priority.
- Undefined:
  - Targets are loaded unmodified.
  - misaligned is tied 0.

Test Plan:
- Reset and run: rst=0 mid-run with addrOut=0x40. addrOut is 0 immediately (asynchronous); after release it reads 0, 4, 8, 12 on successive edges.
- Priority: trap=1, redirect=1 (0x200), stall=1 in one cycle -> addrOut=0x100 and rasCount=0. Next, redirect=1 (0x200) with stall=1 -> addrOut=0x200.
- Call/return: at pc=0x10, call to 0x80 -> 0x80, rasCount=1. Then ret -> 0x14, rasCount=0. Then ret -> 0x18 with a one-cycle rasUnderflow pulse.
- Overflow: 5 nested calls from pcs 0x0, 0x100, 0x200, 0x300, 0x400 (depth 4) -> rasCount=4. Four rets return 0x404, 0x304, 0x204, 0x104; a fifth ret underflows.
- Simultaneous call+ret: RAS top=0x24, pc=0x50, callTarget=0x90 -> addrOut=0x90, top=0x54, rasCount unchanged.
- With PC_MISALIGN_CHECK_EN: redirect to 0x202 -> addrOut=0x100, misaligned pulses, rasCount=0. Without the macro: addrOut=0x202, misaligned stays 0.
